// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with combinational hit path and
// whole-line fill over a request/valid memory handshake.
module instr_cache #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_fetch,
  input  logic        invalidate,
  output logic [31:0] instr_fetch,
  output logic        cache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OB   = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB   = $clog2(LINES);
  localparam int unsigned TAGW = 32 - OB - IB - 2;

  typedef enum logic [1:0] {IDLE, FILL, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OB-1:0]     beat_q, beat_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [IB-1:0]     fidx_q, fidx_d;
  logic [TAGW-1:0]   ftag_q, ftag_d;
  logic              inv_pend_q, inv_pend_d;
  logic              data_we, tag_we;

  logic [31:0]       data_q [LINES][WORDS_PER_LINE];
  logic [TAGW-1:0]   tags_q [LINES];

  logic [OB-1:0]     off_f;
  logic [IB-1:0]     idx_f;
  logic [TAGW-1:0]   tag_f;
  logic              hit;
  logic              unused_pc_bits;

  assign off_f          = pc_fetch[OB+1:2];
  assign idx_f          = pc_fetch[OB+IB+1:OB+2];
  assign tag_f          = pc_fetch[31:OB+IB+2];
  assign unused_pc_bits = ^pc_fetch[1:0];

  assign hit = valid_q[idx_f] && (tags_q[idx_f] == tag_f) && (state_q == IDLE);

  // Outputs are held quiet while reset is asserted, independent of the clock.
  always_comb begin
    cache_stall = 1'b0;
    instr_fetch = '0;
    if (reset) begin
      cache_stall = ~hit;
      if (hit) instr_fetch = data_q[idx_f][off_f];
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    beat_d     = beat_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fidx_d     = fidx_q;
    ftag_d     = ftag_q;
    inv_pend_d = inv_pend_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_fetch[31:OB+2], {(OB+2){1'b0}}};
          beat_d     = '0;
          fidx_d     = idx_f;
          ftag_d     = tag_f;
        end
        if (invalidate) valid_d = '0;
      end
      FILL: begin
        if (mem_rvalid && mem_req_q) begin
          data_we    = 1'b1;
          beat_d     = beat_q + OB'(1);
          mem_addr_d = mem_addr_q + 32'd4;
          if (beat_q == OB'(WORDS_PER_LINE - 1)) begin
            state_d   = UPDATE;
            mem_req_d = 1'b0;
          end
        end
        // The line still completes, but must not become valid afterwards.
        if (invalidate) begin
          valid_d    = '0;
          inv_pend_d = 1'b1;
        end
      end
      UPDATE: begin
        tag_we     = 1'b1;
        if (!inv_pend_q) valid_d[fidx_q] = 1'b1;
        inv_pend_d = 1'b0;
        if (invalidate) valid_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fidx_q     <= '0;
      ftag_q     <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fidx_q     <= fidx_d;
      ftag_q     <= ftag_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[fidx_q][beat_q] <= mem_rdata;
    if (tag_we)  tags_q[fidx_q]         <= ftag_q;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: vector table for cold fill, hits and conflict
// eviction, plus hand sequences for wait states, invalidate and reset mid-fill.
`timescale 1ns/1ps
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_fetch;
  logic        invalidate;
  logic [31:0] instr_fetch;
  logic        cache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int wait_n   = 0;
  int wcnt     = 0;

  instr_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_fetch   (pc_fetch),
    .invalidate (invalidate),
    .instr_fetch(instr_fetch),
    .cache_stall(cache_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word = address + 0x1000, valid every (wait_n+1)-th request cycle.
  assign mem_rvalid = mem_req && (wcnt == wait_n);
  assign mem_rdata  = mem_addr + 32'h1000;

  always @(posedge clk) begin
    if (!mem_req)            wcnt <= 0;
    else if (wcnt == wait_n) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic [31:0] pc, input logic stall, input logic [31:0] instr,
                     input logic req, input logic [31:0] addr);
    vec_t v;
    v.pc = pc; v.stall = stall; v.instr = instr; v.req = req; v.addr = addr;
    vec.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counts stall cycles from the current cycle until a hit, then checks the word.
  task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] exp,
                       input int exp_stalls);
    int n;
    n = 0;
    pc_fetch = pc;
    #1;
    while (cache_stall && n < 100) begin
      n++;
      @(posedge clk); #2;
    end
    chk({name, "_stalls"}, 32'(n), 32'(exp_stalls));
    chk({name, "_instr"}, instr_fetch, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fc;
    reset      = 1'b0;
    pc_fetch   = '0;
    invalidate = 1'b0;

    // cold start and conflict eviction, zero-wait memory
    add(32'h0,   1, 32'h0,    0, 32'h0);
    add(32'h0,   1, 32'h0,    1, 32'h0);
    add(32'h0,   1, 32'h0,    1, 32'h4);
    add(32'h0,   1, 32'h0,    1, 32'h8);
    add(32'h0,   1, 32'h0,    1, 32'hC);
    add(32'h0,   1, 32'h0,    0, 32'h0);
    add(32'h0,   0, 32'h1000, 0, 32'h0);
    add(32'h8,   0, 32'h1008, 0, 32'h0);
    add(32'h4,   0, 32'h1004, 0, 32'h0);
    add(32'hC,   0, 32'h100C, 0, 32'h0);
    add(32'h100, 1, 32'h0,    0, 32'h0);
    add(32'h100, 1, 32'h0,    1, 32'h100);
    add(32'h100, 1, 32'h0,    1, 32'h104);
    add(32'h100, 1, 32'h0,    1, 32'h108);
    add(32'h100, 1, 32'h0,    1, 32'h10C);
    add(32'h100, 1, 32'h0,    0, 32'h0);
    add(32'h100, 0, 32'h1100, 0, 32'h0);
    add(32'h108, 0, 32'h1108, 0, 32'h0);
    add(32'h0,   1, 32'h0,    0, 32'h0);
    add(32'h0,   1, 32'h0,    1, 32'h0);
    add(32'h0,   1, 32'h0,    1, 32'h4);
    add(32'h0,   1, 32'h0,    1, 32'h8);
    add(32'h0,   1, 32'h0,    1, 32'hC);
    add(32'h0,   1, 32'h0,    0, 32'h0);
    add(32'h0,   0, 32'h1000, 0, 32'h0);
    add(32'h4,   0, 32'h1004, 0, 32'h0);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", 32'(cache_stall), 32'd0);
    chk("rst_instr", instr_fetch, 32'h0);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vec[i]) begin
      pc_fetch = vec[i].pc;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(cache_stall), 32'(vec[i].stall));
      chk($sformatf("vec%0d_instr", i), instr_fetch, vec[i].instr);
      chk($sformatf("vec%0d_req", i),   32'(mem_req), 32'(vec[i].req));
      if (vec[i].req) chk($sformatf("vec%0d_addr", i), mem_addr, vec[i].addr);
      @(posedge clk); #1;
    end

    // wait states: rvalid every 3rd fill cycle
    wait_n = 2;
    pc_fetch = 32'h20;
    #1;
    chk("ws_miss", 32'(cache_stall), 32'd1);
    n = 1; fc = 0;
    while (n < 60) begin
      @(posedge clk); #2;
      if (!cache_stall) break;
      n++;
      if (mem_req) begin
        chk("ws_addr", mem_addr, 32'h20 + 32'(4 * (fc / 3)));
        fc++;
      end
    end
    chk("ws_stalls", 32'(n), 32'd14);
    chk("ws_fill_cycles", 32'(fc), 32'd12);
    chk("ws_instr", instr_fetch, 32'h1020);
    wait_n = 0;
    fetch("ws_hit2", 32'h2C, 32'h102C, 0);

    // invalidate on the second fill beat
    pc_fetch = 32'h40;
    #1;
    chk("inv_miss", 32'(cache_stall), 32'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("inv_beat1_addr", mem_addr, 32'h44);
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("inv_refetch_stall", 32'(cache_stall), 32'd1);
    chk("inv_refetch_req0", 32'(mem_req), 32'd0);
    @(posedge clk); #2;
    chk("inv_refetch_req", 32'(mem_req), 32'd1);
    chk("inv_refetch_addr", mem_addr, 32'h40);
    fetch("inv_refill", 32'h40, 32'h1040, 5);
    fetch("inv_line0", 32'h0, 32'h1000, 6);

    // invalidate while idle
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    fetch("idle_inv", 32'h0, 32'h1000, 6);

    // reset in the middle of a fill
    pc_fetch = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmf_req", 32'(mem_req), 32'd1);
    chk("rmf_addr", mem_addr, 32'h84);
    #1;
    reset = 1'b0;
    #1;
    chk("rmf_req_drop", 32'(mem_req), 32'd0);
    chk("rmf_stall", 32'(cache_stall), 32'd0);
    chk("rmf_instr", instr_fetch, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    pc_fetch = 32'h0;
    #1;
    chk("rmf_line0_miss", 32'(cache_stall), 32'd1);
    @(posedge clk); #2;
    chk("rmf_fresh_req", 32'(mem_req), 32'd1);
    chk("rmf_fresh_addr", mem_addr, 32'h0);
    fetch("rmf_refill", 32'h0, 32'h1000, 5);
    fetch("rmf_hit", 32'hC, 32'h100C, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
